// File: rtl/phase_error_detector_if.sv
// Signal bundle between the phase detector and its environment: the two sampled
// clocks going in, the signed error word with its strobe and the lock flag coming out.
interface phase_error_detector_if #(
    parameter int ERROR_WIDTH = 8
);
    logic                          ref_i;
    logic                          fb_i;
    logic signed [ERROR_WIDTH-1:0] error_o;
    logic                          error_valid_o;
    logic                          lock_o;

    modport master (
        output ref_i, fb_i,
        input  error_o, error_valid_o, lock_o
    );

    modport slave (
        input  ref_i, fb_i,
        output error_o, error_valid_o, lock_o
    );
endinterface

// File: rtl/phase_error_detector.sv
// Counter-based phase/frequency detector: times the gap between ref and feedback rising
// edges in gen_clk_i cycles and emits a saturated signed error word plus a lock flag.
module phase_error_detector #(
    parameter int ERROR_WIDTH = 8,
    parameter int CNT_WIDTH   = 10,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_COUNT  = 16
) (
    input logic                   gen_clk_i,
    input logic                   reset_ni,
    phase_error_detector_if.slave pd
);
    localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0]          CNT_MAX = '1;
    localparam logic signed [ERROR_WIDTH-1:0] ERR_MAX = {1'b0, {(ERROR_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, REF_LEAD, FB_LEAD} state_t;

    state_t                        state;
    logic [CNT_WIDTH-1:0]          cnt;
    logic [2:0]                    ref_sync_p0;
    logic [2:0]                    fb_sync_p0;
    logic                          ref_edge_p1;
    logic                          fb_edge_p1;
    logic                          emit;
    logic                          emit_tol;
    logic signed [ERROR_WIDTH-1:0] emit_err;
    logic signed [ERROR_WIDTH-1:0] error_p2;
    logic                          vld_p2;
    logic [LOCK_W-1:0]             lock_cnt;
    logic                          lock_p2;

    // Clip a cycle count to the symmetric range [-ERR_MAX, +ERR_MAX].
    function automatic logic signed [ERROR_WIDTH-1:0] sat_err(
        input logic [CNT_WIDTH-1:0] mag,
        input logic                 neg
    );
        logic signed [ERROR_WIDTH-1:0] clip;
        if (32'(mag) > 32'(ERR_MAX))
            clip = ERR_MAX;
        else
            clip = ERROR_WIDTH'(mag);
        return neg ? -clip : clip;
    endfunction

    // Stage p0/p1: two-flop synchronizer, previous-value flop, registered edge flag.
    always_ff @(posedge gen_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ref_sync_p0 <= '0;
            fb_sync_p0  <= '0;
            ref_edge_p1 <= 1'b0;
            fb_edge_p1  <= 1'b0;
        end else begin
            ref_sync_p0 <= {ref_sync_p0[1:0], pd.ref_i};
            fb_sync_p0  <= {fb_sync_p0[1:0], pd.fb_i};
            ref_edge_p1 <= ref_sync_p0[1] & ~ref_sync_p0[2];
            fb_edge_p1  <= fb_sync_p0[1] & ~fb_sync_p0[2];
        end
    end

    always_comb begin
        emit     = 1'b0;
        emit_tol = 1'b0;
        emit_err = '0;
        case (state)
            IDLE: begin
                if (ref_edge_p1 && fb_edge_p1) begin
                    emit     = 1'b1;
                    emit_tol = 1'b1;
                end
            end
            REF_LEAD: begin
                if (fb_edge_p1) begin
                    emit     = 1'b1;
                    emit_err = sat_err(cnt, 1'b0);
                    emit_tol = (cnt <= CNT_WIDTH'(LOCK_TOL));
                end else if (ref_edge_p1 || cnt == CNT_MAX) begin
                    emit     = 1'b1;
                    emit_err = ERR_MAX;
                end
            end
            FB_LEAD: begin
                if (ref_edge_p1) begin
                    emit     = 1'b1;
                    emit_err = sat_err(cnt, 1'b1);
                    emit_tol = (cnt <= CNT_WIDTH'(LOCK_TOL));
                end else if (fb_edge_p1 || cnt == CNT_MAX) begin
                    emit     = 1'b1;
                    emit_err = -ERR_MAX;
                end
            end
            default: ;
        endcase
    end

    // Stage p2: measurement FSM with registered error word, strobe and lock tracking.
    always_ff @(posedge gen_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            error_p2 <= '0;
            vld_p2   <= 1'b0;
            lock_cnt <= '0;
            lock_p2  <= 1'b0;
        end else begin
            vld_p2 <= emit;
            if (emit) begin
                error_p2 <= emit_err;
                if (emit_tol) begin
                    if (lock_cnt != LOCK_W'(LOCK_COUNT))
                        lock_cnt <= lock_cnt + 1'b1;
                    lock_p2 <= (lock_cnt >= LOCK_W'(LOCK_COUNT - 1));
                end else begin
                    lock_cnt <= '0;
                    lock_p2  <= 1'b0;
                end
            end
            case (state)
                IDLE: begin
                    if (ref_edge_p1 && !fb_edge_p1) begin
                        state <= REF_LEAD;
                        cnt   <= CNT_WIDTH'(1);
                    end else if (fb_edge_p1 && !ref_edge_p1) begin
                        state <= FB_LEAD;
                        cnt   <= CNT_WIDTH'(1);
                    end
                end
                REF_LEAD: begin
                    if (fb_edge_p1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (ref_edge_p1) begin
                        cnt <= CNT_WIDTH'(1);
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FB_LEAD: begin
                    if (ref_edge_p1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (fb_edge_p1) begin
                        cnt <= CNT_WIDTH'(1);
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign pd.error_o       = error_p2;
    assign pd.error_valid_o = vld_p2;
    assign pd.lock_o        = lock_p2;
endmodule
